// File: rtl/display_mux_4dig.sv
// Scan controller for a 4-digit common-anode 7-segment display: holds a BCD value,
// steps through the digits with a guard interval, leading-zero blanking and a frame pulse.
module display_mux_4dig #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        lz_blank_en,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        err,
    output logic        frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       hex_q, hex_d;
    logic [3:0]       an_q, an_d;
    logic             err_q, err_d;
    logic             frame_tick_q, frame_tick_d;
    logic             blank_q, blank_d;

    logic [3:0] digit_ok;
    logic [3:0] upper_zero;
    logic       wrap;
    logic [1:0] idx_nxt;

    // upper_zero[i]: digits i..3 of the held value are all zero
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit_ok[gi]   = (bcd_in[4*gi +: 4] <= 4'd9);
        assign upper_zero[gi] = (data_q[15:4*gi] == '0);
    end

    always_comb begin
        data_d       = data_q;
        err_d        = 1'b0;
        hex_d        = hex_q;
        blank_d      = blank_q;
        frame_tick_d = 1'b0;
        an_d         = 4'b1111;

        if (load) begin
            if (&digit_ok) data_d = bcd_in;
            else           err_d  = 1'b1;
        end

        wrap    = (cnt_q == CNT_LAST);
        idx_nxt = idx_q + 2'd1;
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d   = wrap ? idx_nxt : idx_q;

        // The new slot's digit and blank flag come from data before this edge
        if (wrap) begin
            hex_d        = data_q[4*idx_nxt +: 4];
            blank_d      = lz_blank_en && (idx_nxt != 2'd0) && upper_zero[idx_nxt];
            frame_tick_d = (idx_q == 2'd3);
        end

        // Anodes are computed from next-cycle state so the register drives them directly
        if (!(int'(cnt_d) < GUARD) && !blank_d)
            an_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            hex_q        <= '0;
            an_q         <= 4'b1111;
            err_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hex_q        <= hex_d;
            an_q         <= an_d;
            err_q        <= err_d;
            frame_tick_q <= frame_tick_d;
            blank_q      <= blank_d;
        end
    end

    assign hex        = hex_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_mux_4dig.sv
// Directed bench for display_mux_4dig (REFRESH_DIV=8, GUARD=2): per-slot expectations
// are queued as stimulus is chosen and checked cycle by cycle while the slot runs.
module tb_display_mux_4dig;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_blank_en;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        err;
    logic        frame_tick;

    display_mux_4dig #(.REFRESH_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .lz_blank_en(lz_blank_en),
        .hex        (hex),
        .an         (an),
        .err        (err),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;   // 4'b1111 means the slot is blanked
    } slot_exp_t;

    slot_exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int slot_idx = 0;
    bit first    = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] h, input logic [3:0] a);
        slot_exp_t e;
        e.hex = h;
        e.an  = a;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one slot from cnt=0. Optional load at edge leaving cnt=ld_k, expected err
    // at cnt=err_k, early return after checking cnt=stop_k.
    task automatic run_slot(input int ld_k, input logic [15:0] ld_val, input int err_k,
                            input int stop_k);
        slot_exp_t e;
        logic [3:0] exp_an;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty slot=%0d observed=0 expected=entry", slot_idx);
            e = '{hex: 4'h0, an: 4'hF};
        end else begin
            e = sb.pop_front();
        end
        for (int k = 0; k < 8; k++) begin
            exp_an = (k < 2) ? 4'b1111 : e.an;
            chk($sformatf("hex s%0d k%0d", slot_idx, k), {4'h0, hex}, {4'h0, e.hex});
            chk($sformatf("an s%0d k%0d", slot_idx, k), {4'h0, an}, {4'h0, exp_an});
            chk($sformatf("err s%0d k%0d", slot_idx, k), {7'h0, err}, {7'h0, (k == err_k)});
            chk($sformatf("ftick s%0d k%0d", slot_idx, k), {7'h0, frame_tick},
                {7'h0, (k == 0 && slot_idx == 0 && !first)});
            if (k == 0) first = 1'b0;
            if (k == stop_k) return;
            if (k == ld_k) begin
                load   = 1'b1;
                bcd_in = ld_val;
            end
            step();
            load   = 1'b0;
            bcd_in = 16'h0;
        end
        slot_idx = (slot_idx + 1) % 4;
    endtask

    initial begin
        reset_n     = 1'b0;
        load        = 1'b0;
        bcd_in      = 16'h0;
        lz_blank_en = 1'b0;

        // 1: reset values, then scanning with data = 0
        repeat (5) begin
            @(negedge clk);
            chk("rst_an", {4'h0, an}, 8'h0F);
            chk("rst_hex", {4'h0, hex}, 8'h00);
            chk("rst_err", {7'h0, err}, 8'h00);
            chk("rst_ftick", {7'h0, frame_tick}, 8'h00);
        end
        reset_n = 1'b1;
        push(4'h0, 4'b1110); push(4'h0, 4'b1101); push(4'h0, 4'b1011); push(4'h0, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(3, 16'h1234, -1, -1);

        // 2: 1234 without blanking; 4: rejected 12A4 in slot 3
        push(4'h4, 4'b1110); push(4'h3, 4'b1101); push(4'h2, 4'b1011); push(4'h1, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(2, 16'h12A4, 3, -1);

        push(4'h4, 4'b1110); push(4'h3, 4'b1101); push(4'h2, 4'b1011); push(4'h1, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        lz_blank_en = 1'b1;
        run_slot(2, 16'h0045, -1, -1);

        // 3: 0045 then 0000 with leading-zero blanking
        push(4'h5, 4'b1110); push(4'h4, 4'b1101); push(4'h0, 4'b1111); push(4'h0, 4'b1111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(2, 16'h0000, -1, -1);

        push(4'h0, 4'b1110); push(4'h0, 4'b1111); push(4'h0, 4'b1111); push(4'h0, 4'b1111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        lz_blank_en = 1'b0;
        run_slot(2, 16'h1234, -1, -1);

        // 5: mid-slot load keeps the current digit; wrap-edge load lands one slot later
        push(4'h4, 4'b1110); push(4'h3, 4'b1101); push(4'h6, 4'b1011); push(4'h5, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(3, 16'h5678, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);

        push(4'h8, 4'b1110); push(4'h7, 4'b1101); push(4'h6, 4'b1011); push(4'h1, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(7, 16'h1234, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);

        // 6: asynchronous reset at cnt=5 of slot 2 with a load pending
        push(4'h4, 4'b1110); push(4'h3, 4'b1101); push(4'h2, 4'b1011); push(4'h1, 4'b0111);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, 5);
        #2;
        reset_n = 1'b0;
        load    = 1'b1;
        bcd_in  = 16'h9999;
        #1;
        chk("async_an", {4'h0, an}, 8'h0F);
        chk("async_hex", {4'h0, hex}, 8'h00);
        chk("async_err", {7'h0, err}, 8'h00);
        chk("async_ftick", {7'h0, frame_tick}, 8'h00);
        sb.delete();
        repeat (2) @(negedge clk);
        load   = 1'b0;
        bcd_in = 16'h0;
        chk("rst2_an", {4'h0, an}, 8'h0F);
        reset_n  = 1'b1;
        slot_idx = 0;
        first    = 1'b1;
        push(4'h0, 4'b1110); push(4'h0, 4'b1101);
        run_slot(-1, 16'h0, -1, -1);
        run_slot(-1, 16'h0, -1, -1);

        chk("sb_drained", 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_mux_4dig.md
# display_mux_4dig

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It holds a 4-digit BCD value loaded by the host logic and cycles through the digits at a programmable refresh rate. It drives the 4-bit digit code into the downstream BCD-to-7-segment decoder and drives the active-low anode lines directly. It also provides leading-zero blanking, an anti-ghosting guard interval, BCD validation on load, and a frame pulse.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clk cycles per digit slot; must be ≥ GUARD+1 and ≥ 2.
- GUARD, default 2: cycles at the start of each slot during which all anodes are off; must be ≥ 0.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- load, input, 1: single-cycle request to capture bcd_in.
- bcd_in, input, 16: four BCD digits. [3:0] is digit 0 (least significant, rightmost); [15:12] is digit 3.
- lz_blank_en, input, 1: enables leading-zero blanking. Sampled continuously.
- hex, output, 4: registered digit code fed to the decoder; always 0..9.
- an, output, 4: registered active-low anode enables; an[i] drives digit i.
- err, output, 1: one-cycle pulse when a load is rejected.
- frame_tick, output, 1: one-cycle pulse at the start of each digit-0 slot.

## Operation

- Registered state:
  - data[15:0]: displayed value.
  - cnt: slot prescaler, width clog2(REFRESH_DIV).
  - idx[1:0]: current digit.
  - hex, an, err, frame_tick.
  - blank_q: blank flag for the current slot.
- Reset (asynchronous, while reset_n=0): data=0, cnt=0, idx=0, hex=0, an=4'b1111, blank_q=0, err=0, frame_tick=0.
- Load handling:
  - On an edge with load=1, all four nibbles ≤ 9: data <= bcd_in.
  - On an edge with load=1 and any nibble > 9: data is unchanged and err=1 for the next cycle only.
  - Loads do not affect cnt or idx.
- Prescaler:
  - cnt increments every cycle.
  - When cnt = REFRESH_DIV-1: cnt <= 0 and idx <= idx+1 (3 wraps to 0).
- Slot start (the same wrap edge):
  - hex <= data[4*(idx+1) +: 4], using data as it stood before the edge.
  - blank_q is latched on the same edge.
  - A load on that same edge is not visible until the following slot.
- Leading-zero blanking: digit i is blanked if lz_blank_en=1, i ≥ 1, and digits i..3 of data are all zero. Digit 0 is never blanked.
- Anodes, for a cycle where cnt=k in slot idx:
  - an = 4'b1111 if k < GUARD or blank_q=1.
  - Otherwise an = ~(4'b0001 << idx).
  - an must be registered and glitch-free; only one anode is ever low.
- hex keeps its value for the whole slot, including guard and blanked cycles.
- frame_tick=1 for exactly the cycle in which idx=0 and cnt=0, excluding the first cycle after reset release.

## Timing

- Slot length is REFRESH_DIV cycles; frame length is 4·REFRESH_DIV cycles.
- After reset release, slot 0 starts immediately with cnt=0, hex=0 and an=1111 for GUARD cycles.
- The first slot-0 digit is 0, since data=0 after reset; blank_q=0, so digit 0 is shown.
- Load-to-display latency: a load shows up at the next slot start strictly after the load edge. Worst case is one slot plus one cycle before that slot's digit changes; a full frame is needed before all digits reflect it.
- err is asserted on the cycle after the rejected load edge.
- Reset asserted mid-slot: all outputs take their reset values immediately, independent of clk, and any pending load is discarded.

## Test plan

Bench parameters: REFRESH_DIV=8, GUARD=2.

1. Hold reset_n=0 for 5 cycles, then release → during reset an=1111, hex=0, err=0, frame_tick=0. After release: idx advances every 8 cycles; slot 0 shows hex=0, with an=1111 at cnt 0–1 and an=1110 at cnt 2–7.
2. Load 16'h1234 with lz_blank_en=0 → slots show hex=4/an=1110, hex=3/an=1101, hex=2/an=1011, hex=1/an=0111. an=1111 during cnt 0–1 of every slot. frame_tick pulses every 32 cycles.
3. Load 16'h0045 with lz_blank_en=1 → digits 3 and 2 have an=1111 for the whole slot (hex=0); digits 1 and 0 show 4 and 5. Then load 16'h0000 → only digit 0 lights, showing hex=0.
4. Load 16'h12A4 after 16'h1234 → err=1 for exactly 1 cycle; display continues showing 1234 unchanged.
5. Load 16'h5678 at cnt=3 of slot 1 → slot 1 keeps hex=3 through cnt=7; slot 2 shows hex=6. Separately, load on the exact wrap edge into slot 2 → slot 2 shows the old digit and slot 3 shows the new one.
6. Assert reset_n=0 at cnt=5 of slot 2, then release → an=1111 asynchronously, data cleared; after release scanning restarts at idx=0, cnt=0 with no frame_tick on that first cycle.
